// File: rtl/encoder_8to3_hs.sv
// Registered 8-to-3 priority encoder with valid/ready handshakes on both sides.
// Optional saturating error counter enabled by `define ENCODER_8TO3_ERR_CNT_EN.
module encoder_8to3_hs #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_y,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             a0,
  output logic             a1,
  output logic             a2,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             cnt_clr
`ifdef ENCODER_8TO3_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0] err_cnt
`endif
);

  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  state_t     state_reg, state_next;
  logic [2:0] idx_reg, idx_next;
  logic       err_reg, err_next;
  logic [7:0] sel;
  logic [2:0] enc_idx;
  logic       enc_err;
  logic       accept;

  // sel keeps only the highest set bit, so multi-hot words resolve upward.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_sel
      if (gi == 7) begin : g_top
        assign sel[gi] = in_y[gi];
      end else begin : g_low
        assign sel[gi] = in_y[gi] & ~(|in_y[7:gi+1]);
      end
    end
  endgenerate

  assign enc_idx = {|(sel & 8'hF0), |(sel & 8'hCC), |(sel & 8'hAA)};
  assign enc_err = (in_y == 8'h00) | ((in_y & (in_y - 8'd1)) != 8'h00);

  assign out_valid = (state_reg == ST_FULL);
  assign in_ready  = ~out_valid | out_ready;
  assign accept    = in_valid & in_ready;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    err_next   = err_reg;
    case (state_reg)
      ST_EMPTY: if (accept) state_next = ST_FULL;
      ST_FULL: begin
        if (accept)         state_next = ST_FULL;
        else if (out_ready) state_next = ST_EMPTY;
      end
      default: state_next = ST_EMPTY;
    endcase
    if (accept) begin
      idx_next = enc_idx;
      err_next = enc_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_EMPTY;
      idx_reg   <= 3'd0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      err_reg   <= err_next;
    end
  end

  assign a0      = idx_reg[2];
  assign a1      = idx_reg[1];
  assign a2      = idx_reg[0];
  assign out_err = err_reg;

`ifdef ENCODER_8TO3_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_reg, err_cnt_next;

  // Clear wins over a same-cycle increment.
  always_comb begin
    err_cnt_next = err_cnt_reg;
    if (cnt_clr)
      err_cnt_next = '0;
    else if (accept && enc_err && (err_cnt_reg != {CNT_W{1'b1}}))
      err_cnt_next = err_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_reg <= '0;
    else        err_cnt_reg <= err_cnt_next;
  end

  assign err_cnt = err_cnt_reg;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr & (CNT_W >= 2);
`endif

endmodule

// File: tb/tb_encoder_8to3_hs.sv
// Scoreboard bench for encoder_8to3_hs; the counter checks are active when
// ENCODER_8TO3_ERR_CNT_EN is defined.
module tb_encoder_8to3_hs;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       in_y;
  logic             in_valid;
  logic             in_ready;
  logic             a0, a1, a2;
  logic             out_err;
  logic             out_valid;
  logic             out_ready;
  logic             cnt_clr;
`ifdef ENCODER_8TO3_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt;
`endif

  encoder_8to3_hs #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_y      (in_y),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a0        (a0),
    .a1        (a1),
    .a2        (a2),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cnt_clr   (cnt_clr)
`ifdef ENCODER_8TO3_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] sb[$];   // {err, idx[2:0]}
  int exp_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [3:0] model(input logic [7:0] y);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (y[k]) begin
        idx = 3'(k);
        break;
      end
    end
    return {($countones(y) != 1), idx};
  endfunction

  // One cycle: drive at negedge, check, then retire/accept on the posedge.
  task automatic step(input logic v, input logic [7:0] y, input logic ordy, input logic clr);
    logic fire_in, fire_out, exp_ready;
    in_valid  = v;
    in_y      = y;
    out_ready = ordy;
    cnt_clr   = clr;
    #1;
    exp_ready = (sb.size() == 0) || ordy;
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      check("index", 32'({a0, a1, a2}), 32'(sb[0][2:0]));
      check("out_err", 32'(out_err), 32'(sb[0][3]));
    end
`ifdef ENCODER_8TO3_ERR_CNT_EN
    check("err_cnt", 32'(err_cnt), 32'(exp_cnt));
`endif
    fire_in  = v && exp_ready;
    fire_out = (sb.size() != 0) && ordy;
    $display("t=%0t v=%0b y=%02h ordy=%0b clr=%0b acc=%0b drn=%0b idx=%0d err=%0b",
             $time, v, y, ordy, clr, fire_in, fire_out, {a0, a1, a2}, out_err);
    @(posedge clk);
    if (fire_out) void'(sb.pop_front());
    if (fire_in) sb.push_back(model(y));
    if (clr) exp_cnt = 0;
    else if (fire_in && model(y)[3] && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; in_y = 8'h00; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // One-hot sweep, back to back.
    for (int k = 0; k < 8; k++) step(1'b1, 8'(1 << k), 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Error words.
    step(1'b1, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'hFF, 1'b1, 1'b0);
    step(1'b1, 8'h24, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
`ifdef ENCODER_8TO3_ERR_CNT_EN
    check("err_cnt_after3", 32'(err_cnt), 32'd3);
`endif

    // Backpressure: held word stays put while in_y changes.
    step(1'b1, 8'h08, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    step(1'b1, 8'h40, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Saturation, then clear colliding with an error accept.
    step(1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'h81, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
`ifdef ENCODER_8TO3_ERR_CNT_EN
    check("err_cnt_sat", 32'(err_cnt), 32'd3);
`endif
    step(1'b1, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
`ifdef ENCODER_8TO3_ERR_CNT_EN
    check("err_cnt_clr", 32'(err_cnt), 32'd0);
`endif

    // Mixed random stream with random backpressure.
    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);

    // Reset mid-transfer: fill and stall, then assert reset off-edge.
    step(1'b1, 8'h90, 1'b0, 1'b0);
    step(1'b1, 8'h10, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_index", 32'({a0, a1, a2}), 32'd0);
    check("midrst_out_err", 32'(out_err), 32'd0);
`ifdef ENCODER_8TO3_ERR_CNT_EN
    check("midrst_err_cnt", 32'(err_cnt), 32'd0);
`endif
    sb.delete();
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h02, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
